// File: rtl/video_pkg.sv
// Shared constants for the video fetch stage: FSM encoding, default FIFO geometry, word width.
package video_pkg;

    localparam int VW           = 16;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_AW       = 2;
    localparam int DEF_HEADROOM = 2;

    typedef enum logic [1:0] {
        VF_IDLE  = 2'd0,
        VF_FETCH = 2'd1,
        VF_DRAIN = 2'd2
    } vf_state_e;

endpackage

// File: rtl/video_fifo_sync.sv
// Small synchronous FIFO for fetched video words: zero-latency head output, flush, and
// same-cycle push+pop while full.
module video_fifo_sync
    import video_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [VW-1:0] wdata,
    input  logic          pop_req,
    output logic [VW-1:0] rdata,
    output logic [AW:0]   level,
    output logic [AW:0]   level_next,
    output logic          full,
    output logic          empty,
    output logic          pop_ok
);

    logic [VW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == (AW+1)'(DEPTH));
        pop_ok  = pop_req && !empty && !flush;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        push_ok = push && (!full || pop_ok) && !flush;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            wptr_d  = wptr_q + AW'(push_ok);
            rptr_d  = rptr_q + AW'(pop_ok);
            level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage has no reset; the head output is masked while empty instead.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (push_ok && (wptr_q == AW'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata      = empty ? '0 : mem_q[rptr_q];
    assign level      = level_q;
    assign level_next = level_d;

endmodule

// File: rtl/video_fetch.sv
// Video fetch stage: owns video_go toward the arbiter, buffers strobed words for the renderer.
// Optional per-line word statistics output enabled by defining VIDEO_FETCH_STAT_EN.
module video_fetch
    import video_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = DEF_AW,
    parameter int HEADROOM = DEF_HEADROOM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_start,
    input  logic          fetch_end,
    input  logic          line_start,
    input  logic          video_strobe,
    input  logic [VW-1:0] video_data,
    output logic          video_go,
    output logic [VW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          ovf,
`ifdef VIDEO_FETCH_STAT_EN
    output logic [7:0]    words_line,
`endif
    output logic [AW:0]   level
);

    vf_state_e   state_q, state_d;
    logic        go_q, go_d;
    logic        ovf_q, ovf_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop_ok;
    logic [AW:0] level_next;

    video_fifo_sync #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (line_start),
        .push       (video_strobe),
        .wdata      (video_data),
        .pop_req    (pix_ready),
        .rdata      (pix_data),
        .level      (level),
        .level_next (level_next),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .pop_ok     (pop_ok)
    );

    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = VF_IDLE;
        end else begin
            unique case (state_q)
                VF_IDLE: begin
                    if (fetch_start && !fetch_end) state_d = VF_FETCH;
                end
                VF_FETCH: begin
                    if (fetch_end) state_d = VF_DRAIN;
                end
                VF_DRAIN: begin
                    if (fetch_start && !fetch_end) state_d = VF_FETCH;
                    else if (level == '0)          state_d = VF_IDLE;
                end
                default: state_d = VF_IDLE;
            endcase
        end
        // Keep enough free slots for a request already granted plus the strobe in flight.
        go_d  = (state_d == VF_FETCH) && ((DEPTH - int'(level_next)) >= HEADROOM);
        ovf_d = ovf_q | (video_strobe && fifo_full && !pop_ok && !line_start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VF_IDLE;
            go_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            ovf_q   <= ovf_d;
        end
    end

    assign video_go  = go_q;
    assign ovf       = ovf_q;
    assign pix_valid = !fifo_empty;

`ifdef VIDEO_FETCH_STAT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] words_line_q, words_line_d;
    logic       accepted;

    always_comb begin
        accepted     = video_strobe && !line_start && (!fifo_full || pop_ok);
        cnt_d        = cnt_q;
        words_line_d = words_line_q;
        if (line_start) begin
            words_line_d = cnt_q;
            cnt_d        = '0;
        end else if (accepted && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            words_line_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            words_line_q <= words_line_d;
        end
    end

    assign words_line = words_line_q;
`endif

endmodule

// File: tb/tb_video_fetch.sv
// Directed self-checking bench for video_fetch (default DEPTH=4, HEADROOM=2).
module tb_video_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start, fetch_end, line_start;
    logic        video_strobe;
    logic [15:0] video_data;
    logic        video_go;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        ovf;
    logic [2:0]  level;
`ifdef VIDEO_FETCH_STAT_EN
    logic [7:0]  words_line;
`endif

    int n_vec = 0;
    int n_err = 0;

    video_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_start  (fetch_start),
        .fetch_end    (fetch_end),
        .line_start   (line_start),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .video_go     (video_go),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .ovf          (ovf),
`ifdef VIDEO_FETCH_STAT_EN
        .words_line   (words_line),
`endif
        .level        (level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_start = 0; fetch_end = 0; line_start = 0;
        video_strobe = 0; video_data = '0; pix_ready = 0;
        tick(); tick();
        n_vec++; if (video_go !== 1'b0) begin n_err++; $display("FAIL reset_go: got %b want 0", video_go); end
        n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
        n_vec++; if (pix_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", pix_data); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_basic_flow();
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
        fetch_start = 1; tick(); fetch_start = 0;
        n_vec++; if (video_go !== 1'b1) begin n_err++; $display("FAIL flow_go_rise: got %b want 1", video_go); end
        pix_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); tick(); tick();
            video_strobe = 1; video_data = words[i]; tick(); video_strobe = 0;
            n_vec++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL flow_valid%0d: got %b want 1", i, pix_valid); end
            n_vec++; if (pix_data !== words[i]) begin n_err++; $display("FAIL flow_data%0d: got %h want %h", i, pix_data, words[i]); end
            tick();
            n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL flow_popped%0d: got %b want 0", i, pix_valid); end
            $display("flow word %0d = %h", i, words[i]);
        end
        n_vec++; if (video_go !== 1'b1) begin n_err++; $display("FAIL flow_go_hold: got %b want 1", video_go); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL flow_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_backpressure();
        pix_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            video_strobe = 1; video_data = 16'hA000 + 16'(i); tick();
            n_vec++; if (level !== 3'(i)) begin n_err++; $display("FAIL bp_level%0d: got %0d want %0d", i, level, i); end
            n_vec++; if (video_go !== (i < 3)) begin n_err++; $display("FAIL bp_go%0d: got %b want %b", i, video_go, (i < 3)); end
            $display("backpressure push %0d level %0d", i, level);
        end
        video_strobe = 0;
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_order [4];
        exp_order[0] = 16'hA002; exp_order[1] = 16'hA003; exp_order[2] = 16'hA004; exp_order[3] = 16'hBEEF;
        video_strobe = 1; video_data = 16'hDEAD; pix_ready = 0; tick();
        n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", level); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
        n_vec++; if (pix_data !== 16'hA001) begin n_err++; $display("FAIL ovf_head: got %h want a001", pix_data); end
        video_data = 16'hBEEF; pix_ready = 1; tick(); video_strobe = 0;
        n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_pushpop_level: got %0d want 4", level); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL full_pushpop_ovf: got %b want 1", ovf); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (pix_data !== exp_order[i]) begin n_err++; $display("FAIL ovf_order%0d: got %h want %h", i, pix_data, exp_order[i]); end
            tick();
        end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL ovf_drained: got %0d want 0", level); end
        n_vec++; if (video_go !== 1'b1) begin n_err++; $display("FAIL ovf_go_back: got %b want 1", video_go); end
        pix_ready = 0; line_start = 1; tick(); line_start = 0;
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        n_vec++; if (video_go !== 1'b0) begin n_err++; $display("FAIL ovf_flush_go: got %b want 0", video_go); end
        $display("overflow scenario done");
    endtask

    task automatic test_drain();
        fetch_start = 1; tick(); fetch_start = 0;
        video_strobe = 1; video_data = 16'h1111; tick();
        video_data = 16'h2222; tick(); video_strobe = 0;
        fetch_end = 1; tick(); fetch_end = 0;
        n_vec++; if (video_go !== 1'b0) begin n_err++; $display("FAIL drain_go: got %b want 0", video_go); end
        n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL drain_level: got %0d want 2", level); end
        video_strobe = 1; video_data = 16'h3333; tick(); video_strobe = 0;
        n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL late_strobe: got %0d want 3", level); end
        fetch_start = 1; pix_ready = 1; tick(); fetch_start = 0;
        n_vec++; if (video_go !== 1'b1) begin n_err++; $display("FAIL refetch_go: got %b want 1", video_go); end
        n_vec++; if (pix_data !== 16'h2222) begin n_err++; $display("FAIL refetch_kept: got %h want 2222", pix_data); end
        fetch_end = 1; tick(); fetch_end = 0;
        n_vec++; if (video_go !== 1'b0) begin n_err++; $display("FAIL drain2_go: got %b want 0", video_go); end
        n_vec++; if (pix_data !== 16'h3333) begin n_err++; $display("FAIL late_data: got %h want 3333", pix_data); end
        tick(); pix_ready = 0;
        n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", pix_valid); end
        tick(); tick();
        fetch_start = 1; fetch_end = 1; tick();
        n_vec++; if (video_go !== 1'b0) begin n_err++; $display("FAIL idle_both: got %b want 0", video_go); end
        fetch_end = 0; tick();
        n_vec++; if (video_go !== 1'b1) begin n_err++; $display("FAIL idle_start: got %b want 1", video_go); end
        fetch_end = 1; tick(); fetch_start = 0; fetch_end = 0;
        n_vec++; if (video_go !== 1'b0) begin n_err++; $display("FAIL fetch_both: got %b want 0", video_go); end
        tick();
        $display("drain scenario done");
    endtask

    task automatic test_flush();
        fetch_start = 1; tick(); fetch_start = 0;
        for (int i = 0; i < 3; i++) begin
            video_strobe = 1; video_data = 16'h4441 + 16'(i); tick();
        end
        n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL flush_pre: got %0d want 3", level); end
        video_data = 16'h7777; line_start = 1; tick(); line_start = 0; video_strobe = 0;
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
        n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", pix_valid); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL flush_ovf_kept: got %b want 1", ovf); end
        fetch_start = 1; tick(); fetch_start = 0;
        video_strobe = 1; video_data = 16'h8888; tick(); video_strobe = 0;
        n_vec++; if (pix_data !== 16'h8888) begin n_err++; $display("FAIL flush_discard: got %h want 8888", pix_data); end
        $display("flush scenario done");
    endtask

    task automatic test_reset_mid();
        n_vec++; if (video_go !== 1'b1) begin n_err++; $display("FAIL rst_pre_go: got %b want 1", video_go); end
        rst = 1; tick(); rst = 0;
        n_vec++; if (video_go !== 1'b0) begin n_err++; $display("FAIL rst_go: got %b want 0", video_go); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", pix_valid); end
        $display("mid-window reset done");
    endtask

`ifdef VIDEO_FETCH_STAT_EN
    task automatic test_stats();
        line_start = 1; tick(); line_start = 0;
        pix_ready = 1;
        for (int i = 0; i < 40; i++) begin
            video_strobe = 1; video_data = 16'(i); tick();
        end
        video_strobe = 0; tick();
        line_start = 1; tick(); line_start = 0;
        n_vec++; if (words_line !== 8'd40) begin n_err++; $display("FAIL stat_40: got %0d want 40", words_line); end
        for (int i = 0; i < 300; i++) begin
            video_strobe = 1; video_data = 16'(i); tick();
        end
        video_strobe = 0; tick();
        n_vec++; if (words_line !== 8'd40) begin n_err++; $display("FAIL stat_hold: got %0d want 40", words_line); end
        line_start = 1; tick(); line_start = 0;
        n_vec++; if (words_line !== 8'd255) begin n_err++; $display("FAIL stat_sat: got %0d want 255", words_line); end
        pix_ready = 0;
        $display("statistics done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic_flow();
        test_backpressure();
        test_overflow();
        test_drain();
        test_flush();
        test_reset_mid();
`ifdef VIDEO_FETCH_STAT_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_fetch.md
Name: video_fetch

Overview:
Downstream data stage for the video address/sync top. It owns `video_go` toward the memory arbiter, opening a fetch window between `fetch_start` and `fetch_end`. Words returned on `video_strobe` are captured into a small FIFO, and the pixel renderer pops them with a ready/valid handshake. It throttles requests so that no strobed word is ever lost in normal operation.

Parameters:
- DEPTH, 4: FIFO depth in 16-bit words; power of two, 2..16.
- AW, 2: log2(DEPTH); pointer width.
- HEADROOM, 2: free slots required to keep `video_go` high (covers one in-flight arbiter request plus the strobe registration).

Ports:
- clk in 1: 28 MHz clock.
- rst in 1: synchronous reset, active-high.
- fetch_start in 1: one-cycle pulse from horizontal sync; opens the fetch window.
- fetch_end in 1: one-cycle pulse; closes the fetch window.
- line_start in 1: one-cycle pulse; flushes the FIFO for a new line.
- video_strobe in 1: arbiter data-valid pulse; `video_data` is valid in the same cycle.
- video_data in 16: word from memory.
- video_go out 1: request enable to the arbiter.
- pix_data out 16: FIFO head word.
- pix_valid out 1: FIFO not empty.
- pix_ready in 1: renderer accepts the head word this cycle.
- ovf out 1: sticky overflow flag; cleared by rst only.
- level out AW+1: current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous, on rst=1):
  - State IDLE; pointers 0; level 0.
  - video_go=0, pix_valid=0, pix_data=0, ovf=0.
- State machine: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on fetch_start.
  - FETCH -> DRAIN on fetch_end.
  - DRAIN -> IDLE when level==0.
  - fetch_start in DRAIN -> FETCH; the FIFO is kept.
  - fetch_start and fetch_end in the same cycle -> state unchanged, fetch_end wins if already in FETCH.
- video_go is registered:
  - video_go = (next state FETCH) and (DEPTH - next_level >= HEADROOM).
  - Rises one cycle after fetch_start.
  - Falls one cycle after fetch_end, or one cycle after free space drops below HEADROOM.
- Write:
  - On video_strobe, video_data is written at wptr when level<DEPTH.
  - Writes are accepted in any state; late strobes after fetch_end are still captured.
- Overflow:
  - video_strobe with level==DEPTH and no simultaneous pop -> word dropped, ovf<=1.
  - Strobe and pop in the same cycle while full -> both performed, no overflow.
- Read:
  - pix_data/pix_valid are combinational from the FIFO head (zero latency).
  - A pop occurs when pix_valid & pix_ready; pix_ready with empty FIFO is ignored.
- Level:
  - level += push - pop each cycle.
  - Pointers wrap modulo DEPTH (AW-bit natural wrap).
- line_start flush:
  - Pointers and level go to 0 and state goes to IDLE, in one cycle.
  - Flush overrides a same-cycle push/pop; that word is discarded and ovf is not set.
  - ovf is untouched.
- rst mid-window: everything returns to reset values next cycle; video_go drops immediately (registered, so low in the first post-reset cycle).
- Latency: strobe at cycle N -> pix_valid=1 at N+1 if the FIFO was empty.

Optional Feature:
- VIDEO_FETCH_STAT_EN defined:
  - Adds output `words_line[7:0]`: count of words accepted since the last line_start, saturating at 255.
  - On line_start the count is latched into `words_line` and the counter is cleared.
  - rst clears both.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package `video_pkg`:
  - state encoding constants VF_IDLE=2'd0, VF_FETCH=2'd1, VF_DRAIN=2'd2;
  - default DEPTH/AW/HEADROOM;
  - word width constant VW=16.
- Sub-module `video_fifo_sync` (push/pop/level/full/empty, register array, synchronous reset) instantiated once.
- State machine, video_go, ovf and statistics stay in the top.

Test Plan:
- Basic flow:
  - Stimulus: fetch_start; arbiter strobes every 4 cycles with 0x1234, 0x5678, 0x9ABC; pix_ready=1.
  - Required: video_go=1 from the cycle after fetch_start; pix_data order 0x1234, 0x5678, 0x9ABC, each valid one cycle after its strobe; ovf=0.
- Backpressure:
  - Stimulus: pix_ready=0, strobe every cycle while video_go is high.
  - Required: video_go falls when level reaches 3 (DEPTH=4, HEADROOM=2); the in-flight strobe fills to level 4; ovf=0.
- Overflow:
  - Stimulus: force a strobe at level==4 with pix_ready=0.
  - Required: word dropped, ovf=1 and sticky across line_start; strobe plus pop while full gives level stays 4 and ovf unchanged.
- Window end and drain:
  - Stimulus: fetch_end with level=2.
  - Required: video_go=0 next cycle; state DRAIN; after 2 pops, level=0 and state IDLE.
  - Stimulus: a late strobe in DRAIN.
  - Required: it is captured.
- Flush and reset:
  - Stimulus: line_start with level=3 and a simultaneous strobe.
  - Required: level=0 and pix_valid=0 next cycle.
  - Stimulus: rst during FETCH.
  - Required: video_go=0, ovf=0, level=0 next cycle.
- Statistics (VIDEO_FETCH_STAT_EN):
  - Stimulus: 40 accepted words then line_start.
  - Required: words_line=40.
  - Stimulus: 300 accepted words in one line.
  - Required: words_line=255.
